// File: rtl/seg_scan_mux_if.sv
// Bus bundle for seg_scan_mux: scan control and digit data in, display drive out.
// master = the side supplying data (datapath/testbench), slave = the scanner.
interface seg_scan_mux_if #(
  parameter int N_DIGITS = 8,
  parameter int DIGIT_W  = 4
);
  localparam int SEL_W = $clog2(N_DIGITS);

  logic                         en;
  logic [N_DIGITS*DIGIT_W-1:0]  d;
  logic [N_DIGITS-1:0]          dp_mask;
  logic [DIGIT_W-1:0]           y;
  logic [N_DIGITS-1:0]          an;
  logic                         dp;
  logic [SEL_W-1:0]             sel;
  logic                         frame_pulse;

  modport master (
    output en, d, dp_mask,
    input  y, an, dp, sel, frame_pulse
  );

  modport slave (
    input  en, d, dp_mask,
    output y, an, dp, sel, frame_pulse
  );
endinterface

// File: rtl/seg_scan_mux.sv
// seg_scan_mux: time-multiplexed seven-segment digit scanner.
// Prescaled digit stepping, per-frame snapshot of the digit word (no tearing),
// one-hot active-high anode drive, decimal-point select and a frame-wrap pulse.
// Optional build macro LEADING_ZERO_BLANK_EN: darkens digits above the highest
// nonzero digit of the frame snapshot (digit 0 always lit).
module seg_scan_mux #(
  parameter int N_DIGITS = 8,
  parameter int DIGIT_W  = 4,
  parameter int SCAN_DIV = 10000
) (
  input  logic            clk,
  input  logic            rstn,
  seg_scan_mux_if.slave   bus
);
  localparam int SEL_W = $clog2(N_DIGITS);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
  localparam logic [SEL_W-1:0] SEL_MAX = SEL_W'(N_DIGITS - 1);

  logic [CNT_W-1:0]             cnt, cnt_next;
  logic [SEL_W-1:0]             sel_q, sel_next;
  logic [N_DIGITS*DIGIT_W-1:0]  d_q, d_q_next;
  logic [N_DIGITS-1:0]          dp_q, dp_q_next;
  logic                         tick, wrap, snap;
  logic [DIGIT_W-1:0]           y_q, y_next;
  logic [N_DIGITS-1:0]          an_q, an_next;
  logic                         dp_o, dp_next;
  logic                         fp_q;

  // Prescaler, scan index and frame snapshot next-state.
  always_comb begin
    tick     = bus.en && (cnt == CNT_MAX);
    wrap     = (sel_q == SEL_MAX);
    snap     = !bus.en || (tick && wrap);
    cnt_next = '0;
    if (bus.en && !tick)
      cnt_next = cnt + 1'b1;
    sel_next = sel_q;
    if (tick)
      sel_next = wrap ? '0 : sel_q + 1'b1;
    d_q_next  = snap ? bus.d       : d_q;
    dp_q_next = snap ? bus.dp_mask : dp_q;
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [N_DIGITS-1:0] lit;
  logic                seen;

  // Digit i is lit when it or any higher digit of the snapshot is nonzero.
  always_comb begin
    lit    = '0;
    seen   = 1'b0;
    lit[0] = 1'b1;
    for (int unsigned i = N_DIGITS - 1; i >= 1; i--) begin
      seen   = seen | (|d_q_next[i*DIGIT_W +: DIGIT_W]);
      lit[i] = seen;
    end
  end
`endif

  // Output next-state: everything taken from the post-edge digit index and snapshot.
  always_comb begin
    y_next  = '0;
    dp_next = 1'b0;
    an_next = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (sel_next == SEL_W'(i)) begin
        y_next     = d_q_next[i*DIGIT_W +: DIGIT_W];
        dp_next    = dp_q_next[i];
        an_next[i] = bus.en;
      end
    end
`ifdef LEADING_ZERO_BLANK_EN
    an_next = an_next & lit;
`endif
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt   <= '0;
      sel_q <= '0;
      d_q   <= '0;
      dp_q  <= '0;
      y_q   <= '0;
      an_q  <= '0;
      dp_o  <= 1'b0;
      fp_q  <= 1'b0;
    end else begin
      cnt   <= cnt_next;
      sel_q <= sel_next;
      d_q   <= d_q_next;
      dp_q  <= dp_q_next;
      y_q   <= y_next;
      an_q  <= an_next;
      dp_o  <= dp_next;
      fp_q  <= tick && wrap;
    end
  end

  assign bus.y           = y_q;
  assign bus.an          = an_q;
  assign bus.dp          = dp_o;
  assign bus.sel         = sel_q;
  assign bus.frame_pulse = fp_q;
endmodule

// File: tb/tb_seg_scan_mux.sv
// Directed table-driven bench for seg_scan_mux (8 digits x 4 bits, SCAN_DIV=4).
module tb_seg_scan_mux;
  localparam int N_DIGITS = 8;
  localparam int DIGIT_W  = 4;
  localparam int SCAN_DIV = 4;
`ifdef LEADING_ZERO_BLANK_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;

  seg_scan_mux_if #(.N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W)) bus ();

  seg_scan_mux #(.N_DIGITS(N_DIGITS), .DIGIT_W(DIGIT_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  typedef struct {
    logic        en;
    logic [31:0] d;
    logic [7:0]  dpm;
    int          ncyc;
    logic [3:0]  y;
    logic [7:0]  an;
    logic        dp;
    logic [2:0]  sel;
    logic        fp;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s [%0d]: got %h want %h", nm, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [3:0] y, input logic [7:0] an,
                         input logic dp, input logic [2:0] sel, input logic fp);
    chk("y",   idx, 32'(bus.y),           32'(y));
    chk("an",  idx, 32'(bus.an),          32'(an));
    chk("dp",  idx, 32'(bus.dp),          32'(dp));
    chk("sel", idx, 32'(bus.sel),         32'(sel));
    chk("fp",  idx, 32'(bus.frame_pulse), 32'(fp));
  endtask

  task automatic add(input logic en, input logic [31:0] d, input logic [7:0] dpm, input int ncyc,
                     input logic [3:0] y, input logic [7:0] an, input logic dp,
                     input logic [2:0] sel, input logic fp);
    vec_t v;
    v.en = en; v.d = d; v.dpm = dpm; v.ncyc = ncyc;
    v.y = y; v.an = an; v.dp = dp; v.sel = sel; v.fp = fp;
    vecs.push_back(v);
  endtask

  function automatic logic [7:0] lz(input logic [7:0] an);
    return LZB ? 8'h00 : an;
  endfunction

  initial begin
    int fp_cnt, fp_first, oh_bad;

    //   en  d             dpm    n   y     an      dp  sel fp
    // Scan of 76543210, snapshot held through d change at sel 3.
    add(0, 32'h76543210, 8'h00, 1,  4'h0, 8'h00, 0, 0, 0);
    add(1, 32'h76543210, 8'h00, 1,  4'h0, 8'h01, 0, 0, 0);
    add(1, 32'h76543210, 8'h00, 3,  4'h1, 8'h02, 0, 1, 0);
    add(1, 32'h76543210, 8'h00, 4,  4'h2, 8'h04, 0, 2, 0);
    add(1, 32'h76543210, 8'h00, 4,  4'h3, 8'h08, 0, 3, 0);
    add(1, 32'hFFFFFFFF, 8'h00, 4,  4'h4, 8'h10, 0, 4, 0);
    add(1, 32'hFFFFFFFF, 8'h00, 4,  4'h5, 8'h20, 0, 5, 0);
    add(1, 32'hFFFFFFFF, 8'h00, 4,  4'h6, 8'h40, 0, 6, 0);
    add(1, 32'hFFFFFFFF, 8'h00, 4,  4'h7, 8'h80, 0, 7, 0);
    add(1, 32'hFFFFFFFF, 8'h00, 3,  4'h7, 8'h80, 0, 7, 0);
    add(1, 32'hFFFFFFFF, 8'h00, 1,  4'hF, 8'h01, 0, 0, 1);
    add(1, 32'hFFFFFFFF, 8'h00, 1,  4'hF, 8'h01, 0, 0, 0);
    add(1, 32'hFFFFFFFF, 8'h00, 19, 4'hF, 8'h20, 0, 5, 0);
    // Enable drop at sel 5: blank, hold sel, snapshot follows d while disabled.
    add(0, 32'h89ABCDEF, 8'h00, 10, 4'hA, 8'h00, 0, 5, 0);
    add(1, 32'h89ABCDEF, 8'h00, 1,  4'hA, 8'h20, 0, 5, 0);
    add(1, 32'h89ABCDEF, 8'h00, 2,  4'hA, 8'h20, 0, 5, 0);
    add(1, 32'h89ABCDEF, 8'h00, 1,  4'h9, 8'h40, 0, 6, 0);
    // Decimal point: mask takes effect from the next frame.
    add(1, 32'h89ABCDEF, 8'h04, 4,  4'h8, 8'h80, 0, 7, 0);
    add(1, 32'h89ABCDEF, 8'h04, 4,  4'hF, 8'h01, 0, 0, 1);
    add(1, 32'h89ABCDEF, 8'h04, 4,  4'hE, 8'h02, 0, 1, 0);
    add(1, 32'h89ABCDEF, 8'h04, 4,  4'hD, 8'h04, 1, 2, 0);
    add(1, 32'h89ABCDEF, 8'h04, 3,  4'hD, 8'h04, 1, 2, 0);
    add(1, 32'h89ABCDEF, 8'h04, 1,  4'hC, 8'h08, 0, 3, 0);
    // Leading-zero value 00000012.
    add(0, 32'h00000012, 8'h04, 1,  4'h0, 8'h00, 0, 3, 0);
    add(1, 32'h00000012, 8'h04, 1,  4'h0, lz(8'h08), 0, 3, 0);
    add(1, 32'h00000012, 8'h04, 3,  4'h0, lz(8'h10), 0, 4, 0);
    add(1, 32'h00000012, 8'h04, 4,  4'h0, lz(8'h20), 0, 5, 0);
    add(1, 32'h00000012, 8'h04, 4,  4'h0, lz(8'h40), 0, 6, 0);
    add(1, 32'h00000012, 8'h04, 4,  4'h0, lz(8'h80), 0, 7, 0);
    add(1, 32'h00000012, 8'h04, 4,  4'h2, 8'h01,     0, 0, 1);
    add(1, 32'h00000012, 8'h04, 4,  4'h1, 8'h02,     0, 1, 0);
    add(1, 32'h00000012, 8'h04, 4,  4'h0, lz(8'h04), 1, 2, 0);

    bus.en = 1'b0; bus.d = '0; bus.dp_mask = '0;

    // Asynchronous reset asserted between edges takes effect immediately.
    #3 rstn = 1'b0;
    #1 chk_all(-1, 4'h0, 8'h00, 1'b0, 3'd0, 1'b0);
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    foreach (vecs[i]) begin
      bus.en      = vecs[i].en;
      bus.d       = vecs[i].d;
      bus.dp_mask = vecs[i].dpm;
      repeat (vecs[i].ncyc) @(posedge clk);
      #1;
      chk_all(i, vecs[i].y, vecs[i].an, vecs[i].dp, vecs[i].sel, vecs[i].fp);
    end

    // Mid-frame reset (sel=2, dp=1, an lit) clears everything at once.
    #2 rstn = 1'b0;
    #1 chk_all(100, 4'h0, 8'h00, 1'b0, 3'd0, 1'b0);
    bus.en = 1'b1; bus.d = 32'h76543210; bus.dp_mask = 8'h00;
    @(posedge clk); @(posedge clk); #1;
    rstn = 1'b1;

    // Restart at digit 0; frame pulse every 32 clocks; never two digits lit.
    fp_cnt = 0; fp_first = 0; oh_bad = 0;
    for (int k = 1; k <= 65; k++) begin
      @(posedge clk); #1;
      if (k == 1) chk_all(101, 4'h0, 8'h01, 1'b0, 3'd0, 1'b0);
      if (bus.frame_pulse === 1'b1) begin
        fp_cnt++;
        if (fp_first == 0) fp_first = k;
      end
      if (!$onehot0(bus.an)) oh_bad++;
    end
    chk("fp_count", 102, 32'(fp_cnt),   32'd2);
    chk("fp_first", 103, 32'(fp_first), 32'd32);
    chk("onehot",   104, 32'(oh_bad),   32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
